// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit RISC core: opcodes, ALU encoding,
// control FSM states and instruction field positions.
package risc_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_MOV = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_AND    = 3'd2;
  localparam logic [2:0] ALU_OR     = 3'd3;
  localparam logic [2:0] ALU_XOR    = 3'd4;
  localparam logic [2:0] ALU_PASS_A = 3'd5;

  // LSB positions; imm8 overlaps rs1/rs2 by design of the encoding
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

endpackage

// File: rtl/risc_instr_decode.sv
// Combinational decode of the latched instruction word into register
// addresses, immediate, ALU operation and instruction class flags.
module risc_instr_decode
  import risc_pkg::*;
(
  input  logic [15:0] instr,
  output logic [2:0]  alu_op,
  output logic [2:0]  rd,
  output logic [2:0]  rs1,
  output logic [2:0]  rs2,
  output logic [7:0]  imm8,
  output logic        is_alu,
  output logic        is_ldi,
  output logic        is_jmp,
  output logic        is_hlt,
  output logic        is_illegal
);

  logic [3:0] opc;

  assign opc  = instr[OPC_LSB +: 4];
  assign rd   = instr[RD_LSB  +: 3];
  assign rs1  = instr[RS1_LSB +: 3];
  assign rs2  = instr[RS2_LSB +: 3];
  assign imm8 = instr[IMM_LSB +: 8];

  // MOV is routed through the ALU as PASS_A so it shares the EXECUTE path
  always_comb begin
    alu_op     = ALU_ADD;
    is_alu     = 1'b0;
    is_ldi     = 1'b0;
    is_jmp     = 1'b0;
    is_hlt     = 1'b0;
    is_illegal = 1'b0;
    case (opc)
      OP_NOP: begin end
      OP_ADD: begin is_alu = 1'b1; alu_op = ALU_ADD;    end
      OP_SUB: begin is_alu = 1'b1; alu_op = ALU_SUB;    end
      OP_AND: begin is_alu = 1'b1; alu_op = ALU_AND;    end
      OP_OR:  begin is_alu = 1'b1; alu_op = ALU_OR;     end
      OP_XOR: begin is_alu = 1'b1; alu_op = ALU_XOR;    end
      OP_MOV: begin is_alu = 1'b1; alu_op = ALU_PASS_A; end
      OP_LDI: is_ldi = 1'b1;
      OP_JMP: is_jmp = 1'b1;
      OP_HLT: is_hlt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/risc_ctrl_fsm.sv
// Multicycle fetch/decode/execute/writeback controller; owns the PC.
// Optional RISC_CTRL_PERF_EN adds a saturating retired-instruction counter.
module risc_ctrl_fsm
  import risc_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [2:0]      rf_rd_addr1,
  output logic [2:0]      rf_rd_addr2,
  output logic [2:0]      rf_wr_addr,
  output logic            rf_we,
  output logic            rf_wsel,
  output logic [7:0]      rf_imm,
  output logic [2:0]      alu_op,
  output logic [PC_W-1:0] pc,
`ifdef RISC_CTRL_PERF_EN
  output logic [15:0]     retired_cnt,
`endif
  output logic            halted,
  output logic            illegal
);

  state_t      st, st_nxt;
  logic [15:0] ir;
  logic        armed;
  logic        accept;
  logic [7:0]  dec_imm;
  logic        dec_alu, dec_ldi, dec_jmp, dec_hlt, dec_ill;

  risc_instr_decode u_dec (
    .instr      (ir),
    .alu_op     (alu_op),
    .rd         (rf_wr_addr),
    .rs1        (rf_rd_addr1),
    .rs2        (rf_rd_addr2),
    .imm8       (dec_imm),
    .is_alu     (dec_alu),
    .is_ldi     (dec_ldi),
    .is_jmp     (dec_jmp),
    .is_hlt     (dec_hlt),
    .is_illegal (dec_ill)
  );

  // armed keeps imem_req low for the first cycle out of reset
  assign imem_req  = armed && (st == ST_FETCH);
  assign accept    = imem_req && imem_valid;
  assign imem_addr = pc;
  assign rf_we     = (st == ST_WRITEBACK);
  assign rf_wsel   = dec_ldi;
  assign rf_imm    = dec_imm;
  assign halted    = (st == ST_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= ST_FETCH;
      armed <= 1'b0;
    end else begin
      st    <= st_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_FETCH:     if (accept) st_nxt = ST_DECODE;
      ST_DECODE: begin
        if (dec_hlt)      st_nxt = ST_HALT;
        else if (dec_alu) st_nxt = ST_EXECUTE;
        else if (dec_ldi) st_nxt = ST_WRITEBACK;
        else              st_nxt = ST_FETCH;
      end
      ST_EXECUTE:   st_nxt = ST_WRITEBACK;
      ST_WRITEBACK: st_nxt = ST_FETCH;
      ST_HALT:      st_nxt = ST_HALT;
      default:      st_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= '0;
    end else if (accept) begin
      ir <= imem_rdata;
    end
  end

  // JMP in DECODE overrides the increment taken at fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (accept) begin
      pc <= pc + PC_W'(1);
    end else if (st == ST_DECODE && dec_jmp) begin
      pc <= PC_W'(dec_imm);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
    end else if (st == ST_DECODE && dec_ill) begin
      illegal <= 1'b1;
    end
  end

`ifdef RISC_CTRL_PERF_EN
  logic retire;

  assign retire = (st_nxt == ST_FETCH) && (st == ST_DECODE || st == ST_WRITEBACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if (retire && retired_cnt != 16'hFFFF) begin
      retired_cnt <= retired_cnt + 16'd1;
    end
  end
`endif

endmodule
